axi4_stream_pkt_arbiter: RTL and testbench

AXI4_STREAM_PKT_ARBITER -- requirements
Module: axi4_stream_pkt_arbiter

---
 rtl/axi4_stream_pkt_arbiter_if.sv | 27 ++
 rtl/axi4_stream_pkt_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_axi4_stream_pkt_arbiter.sv | 242 ++++++++++++++++++++++++
 3 files changed

// File: rtl/axi4_stream_pkt_arbiter_if.sv
// AXI4-Stream link bundle shared by the packet arbiter's requester inputs and its downstream output.
interface axi4_stream_if #(
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int ID_WIDTH   = 1
);
   logic [DATA_WIDTH-1:0]   tdata;
   logic [DATA_WIDTH/8-1:0] tstrb;
   logic [DATA_WIDTH/8-1:0] tkeep;
   logic                    tlast;
   logic [USER_WIDTH-1:0]   tuser;
   logic [DEST_WIDTH-1:0]   tdest;
   logic [ID_WIDTH-1:0]     tid;
   logic                    tvalid;
   logic                    tready;

   modport master (
      output tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
      input  tready
   );

   modport slave (
      input  tdata, tstrb, tkeep, tlast, tuser, tdest, tid, tvalid,
      output tready
   );
endinterface

// File: rtl/axi4_stream_pkt_arbiter.sv
// Round-robin packet arbiter: NUM_INPUTS AXI4-Stream requesters share one output, one whole packet per grant.
// Optional per-input completed-packet counters on pkt_cnt_o when AXI4_STREAM_PKT_ARBITER_PKT_CNT_EN is defined.
module axi4_stream_pkt_arbiter #(
   parameter int NUM_INPUTS = 4,
   parameter int DATA_WIDTH = 32,
   parameter int USER_WIDTH = 1,
   parameter int DEST_WIDTH = 1,
   parameter int ID_WIDTH   = 1
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   axi4_stream_if.slave          pkt_i [NUM_INPUTS],
   axi4_stream_if.master         pkt_o,
   output logic [NUM_INPUTS-1:0] grant_o,
   output logic                  busy_o
`ifdef AXI4_STREAM_PKT_ARBITER_PKT_CNT_EN
   ,
   output logic [NUM_INPUTS*32-1:0] pkt_cnt_o
`endif
);

   localparam int IDX_W  = $clog2(NUM_INPUTS);
   localparam int SUM_W  = IDX_W + 1;
   localparam int KEEP_W = DATA_WIDTH / 8;

   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] XFER = 1'b1;

   localparam logic [NUM_INPUTS-1:0] ONE_HOT_LSB = {{(NUM_INPUTS-1){1'b0}}, 1'b1};

   logic [DATA_WIDTH-1:0] in_tdata_s [NUM_INPUTS];
   logic [KEEP_W-1:0]     in_tstrb_s [NUM_INPUTS];
   logic [KEEP_W-1:0]     in_tkeep_s [NUM_INPUTS];
   logic [USER_WIDTH-1:0] in_tuser_s [NUM_INPUTS];
   logic [DEST_WIDTH-1:0] in_tdest_s [NUM_INPUTS];
   logic [ID_WIDTH-1:0]   in_tid_s   [NUM_INPUTS];
   logic [NUM_INPUTS-1:0] in_tlast_s;
   logic [NUM_INPUTS-1:0] in_tvalid_s;
   logic [NUM_INPUTS-1:0] in_tready_s;

   logic [DATA_WIDTH-1:0] out_tdata_s;
   logic [KEEP_W-1:0]     out_tstrb_s;
   logic [KEEP_W-1:0]     out_tkeep_s;
   logic [USER_WIDTH-1:0] out_tuser_s;
   logic [DEST_WIDTH-1:0] out_tdest_s;
   logic [ID_WIDTH-1:0]   out_tid_s;
   logic                  out_tlast_s;
   logic                  out_tvalid_s;

   logic [0:0]            state_r;
   logic [NUM_INPUTS-1:0] grant_r;
   logic                  busy_r;
   // sel_r doubles as last_grant: it keeps the last winner after the packet ends
   logic [IDX_W-1:0]      sel_r;

   logic                  req_found_s;
   logic [IDX_W-1:0]      req_idx_s;
   logic [SUM_W-1:0]      cand_s;
   logic                  pkt_end_s;

   genvar k;
   generate
      for (k = 0; k < NUM_INPUTS; k++) begin : g_in
         assign in_tdata_s[k]  = pkt_i[k].tdata;
         assign in_tstrb_s[k]  = pkt_i[k].tstrb;
         assign in_tkeep_s[k]  = pkt_i[k].tkeep;
         assign in_tuser_s[k]  = pkt_i[k].tuser;
         assign in_tdest_s[k]  = pkt_i[k].tdest;
         assign in_tid_s[k]    = pkt_i[k].tid;
         assign in_tlast_s[k]  = pkt_i[k].tlast;
         assign in_tvalid_s[k] = pkt_i[k].tvalid;
         assign pkt_i[k].tready = in_tready_s[k];
      end
   endgenerate

   // Round-robin search for the first valid requester after the last winner.
   always_comb begin
      req_found_s = 1'b0;
      req_idx_s   = {IDX_W{1'b0}};
      cand_s      = {SUM_W{1'b0}};
      for (int i = 0; i < NUM_INPUTS; i++) begin
         cand_s = {1'b0, sel_r} + SUM_W'(1) + SUM_W'(i);
         if (cand_s >= SUM_W'(NUM_INPUTS)) begin
            cand_s = cand_s - SUM_W'(NUM_INPUTS);
         end else begin
            cand_s = cand_s;
         end
         if (!req_found_s && in_tvalid_s[cand_s[IDX_W-1:0]]) begin
            req_found_s = 1'b1;
            req_idx_s   = cand_s[IDX_W-1:0];
         end else begin
            req_found_s = req_found_s;
         end
      end
   end

   // Output mux: granted input passes through in XFER, everything held at zero in IDLE.
   always_comb begin
      out_tdata_s  = {DATA_WIDTH{1'b0}};
      out_tstrb_s  = {KEEP_W{1'b0}};
      out_tkeep_s  = {KEEP_W{1'b0}};
      out_tuser_s  = {USER_WIDTH{1'b0}};
      out_tdest_s  = {DEST_WIDTH{1'b0}};
      out_tid_s    = {ID_WIDTH{1'b0}};
      out_tlast_s  = 1'b0;
      out_tvalid_s = 1'b0;
      in_tready_s  = {NUM_INPUTS{1'b0}};
      if (state_r == XFER) begin
         out_tdata_s  = in_tdata_s[sel_r];
         out_tstrb_s  = in_tstrb_s[sel_r];
         out_tkeep_s  = in_tkeep_s[sel_r];
         out_tuser_s  = in_tuser_s[sel_r];
         out_tdest_s  = in_tdest_s[sel_r];
         out_tid_s    = in_tid_s[sel_r];
         out_tlast_s  = in_tlast_s[sel_r];
         out_tvalid_s = in_tvalid_s[sel_r];
         in_tready_s  = grant_r & {NUM_INPUTS{pkt_o.tready}};
      end else begin
         in_tready_s  = {NUM_INPUTS{1'b0}};
      end
   end

   assign pkt_o.tdata  = out_tdata_s;
   assign pkt_o.tstrb  = out_tstrb_s;
   assign pkt_o.tkeep  = out_tkeep_s;
   assign pkt_o.tuser  = out_tuser_s;
   assign pkt_o.tdest  = out_tdest_s;
   assign pkt_o.tid    = out_tid_s;
   assign pkt_o.tlast  = out_tlast_s;
   assign pkt_o.tvalid = out_tvalid_s;

   assign pkt_end_s = (state_r == XFER) && out_tvalid_s && pkt_o.tready && out_tlast_s;

   // Grant FSM: lock a winner in IDLE, release it on the tlast handshake.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_r <= IDLE;
         grant_r <= {NUM_INPUTS{1'b0}};
         busy_r  <= 1'b0;
         sel_r   <= IDX_W'(NUM_INPUTS - 1);
      end else begin
         case (state_r)
            IDLE: begin
               if (req_found_s) begin
                  state_r <= XFER;
                  grant_r <= ONE_HOT_LSB << req_idx_s;
                  busy_r  <= 1'b1;
                  sel_r   <= req_idx_s;
               end
            end
            XFER: begin
               if (pkt_end_s) begin
                  state_r <= IDLE;
                  grant_r <= {NUM_INPUTS{1'b0}};
                  busy_r  <= 1'b0;
               end
            end
            default: begin
               state_r <= IDLE;
               grant_r <= {NUM_INPUTS{1'b0}};
               busy_r  <= 1'b0;
            end
         endcase
      end
   end

   assign grant_o = grant_r;
   assign busy_o  = busy_r;

`ifdef AXI4_STREAM_PKT_ARBITER_PKT_CNT_EN
   logic [31:0] pkt_cnt_r [NUM_INPUTS];

   // Completed-packet counters, one per input, wrapping naturally at 2^32.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            pkt_cnt_r[i] <= 32'd0;
         end
      end else begin
         for (int i = 0; i < NUM_INPUTS; i++) begin
            if (pkt_end_s && (sel_r == IDX_W'(i))) begin
               pkt_cnt_r[i] <= pkt_cnt_r[i] + 32'd1;
            end
         end
      end
   end

   generate
      for (k = 0; k < NUM_INPUTS; k++) begin : g_cnt
         assign pkt_cnt_o[k*32 +: 32] = pkt_cnt_r[k];
      end
   endgenerate
`endif

endmodule

// File: tb/tb_axi4_stream_pkt_arbiter.sv
// Directed bench for axi4_stream_pkt_arbiter: simple packet sources, grant-sequence checks and an output word log.
module tb_axi4_stream_pkt_arbiter;

   logic       clk_i = 1'b0;
   logic       rst_i = 1'b1;
   logic [3:0] grant_o;
   logic       busy_o;
`ifdef AXI4_STREAM_PKT_ARBITER_PKT_CNT_EN
   logic [127:0] pkt_cnt_o;
`endif

   int checks = 0;
   int errors = 0;

   // Source state: packets left, words per packet, current word, packet number, forced valid drop
   int  pkts_left [4];
   int  len       [4];
   int  word      [4];
   int  pkt_no    [4];
   bit  hold      [4];
   logic [3:0] src_valid;
   logic [3:0] src_ready;
   logic       out_ready = 1'b1;

   logic [31:0] got_q [$];
   logic [31:0] exp_q [$];
   logic [3:0]  exp1 [8] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0100, 4'b0100, 4'b0100, 4'b0000};
   logic [3:0]  exp3 [8] = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b1000, 4'b0000};
   logic [3:0]  exp_g;

   axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) in_if [4] ();
   axi4_stream_if #(.DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)) out_if ();

   genvar k;
   generate
      for (k = 0; k < 4; k++) begin : g_src
         assign src_valid[k]      = (pkts_left[k] != 0) && !hold[k];
         assign in_if[k].tvalid   = src_valid[k];
         assign in_if[k].tdata    = {8'(k), 8'(pkt_no[k]), 16'(word[k])};
         assign in_if[k].tlast    = (word[k] == len[k] - 1);
         assign in_if[k].tstrb    = 4'hF;
         assign in_if[k].tkeep    = 4'hF;
         assign in_if[k].tuser    = 1'(word[k] & 1);
         assign in_if[k].tdest    = 1'((k >> 1) & 1);
         assign in_if[k].tid      = 1'(k & 1);
         assign src_ready[k]      = in_if[k].tready;
      end
   endgenerate
   assign out_if.tready = out_ready;

   axi4_stream_pkt_arbiter #(
      .NUM_INPUTS(4), .DATA_WIDTH(32), .USER_WIDTH(1), .DEST_WIDTH(1), .ID_WIDTH(1)
   ) dut (
      .clk_i   (clk_i),
      .rst_i   (rst_i),
      .pkt_i   (in_if),
      .pkt_o   (out_if),
      .grant_o (grant_o),
      .busy_o  (busy_o)
`ifdef AXI4_STREAM_PKT_ARBITER_PKT_CNT_EN
      ,
      .pkt_cnt_o (pkt_cnt_o)
`endif
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic load(input int idx, input int n, input int l);
      pkts_left[idx] = n;
      len[idx]       = l;
      word[idx]      = 0;
      pkt_no[idx]    = 0;
   endtask

   // One clock: capture handshakes before the edge, advance the sources after it
   task automatic tick();
      bit hs [4];
      #1;
      for (int i = 0; i < 4; i++) hs[i] = src_valid[i] && src_ready[i];
      if (out_if.tvalid && out_if.tready) got_q.push_back(out_if.tdata);
      @(posedge clk_i);
      #1;
      for (int i = 0; i < 4; i++) begin
         if (hs[i]) begin
            if (word[i] == len[i] - 1) begin
               word[i] = 0;
               pkt_no[i]++;
               pkts_left[i]--;
            end else begin
               word[i]++;
            end
         end
      end
      #1;
   endtask

   task automatic chk_stream(input string tag);
      logic [31:0] g;
      chk({tag, "_len"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         g = (i < got_q.size()) ? got_q[i] : 32'hFFFF_FFFF;
         chk(tag, g, exp_q[i]);
      end
      got_q.delete();
      exp_q.delete();
   endtask

   initial begin
      // Reset state
      tick();
      tick();
      chk("rst_grant", 32'(grant_o), 32'h0);
      chk("rst_busy", 32'(busy_o), 32'h0);
      chk("rst_tvalid", 32'(out_if.tvalid), 32'h0);
      chk("rst_tready", 32'(src_ready), 32'h0);

      // Inputs 0 and 2 valid out of reset, 3-word packets
      load(0, 1, 3);
      load(2, 1, 3);
      tick();
      chk("rst_hold_grant", 32'(grant_o), 32'h0);
      rst_i = 1'b0;
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t1_grant", 32'(grant_o), 32'(exp1[i]));
         if (i == 0) chk("t1_first_word", out_if.tdata, 32'h0000_0000);
         if (i == 3) chk("t1_bubble_busy", 32'(busy_o), 32'h0);
         if (i == 4) chk("t1_tdest", 32'(out_if.tdest), 32'h1);
      end
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0000_0000 + 32'(i));
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0200_0000 + 32'(i));
      chk_stream("t1_stream");

      // All four inputs valid, 1-word packets, round-robin from input 0
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      for (int i = 0; i < 4; i++) load(i, 2, 1);
      for (int i = 0; i < 16; i++) begin
         tick();
         exp_g = (i % 2 == 0) ? (4'b0001 << ((i / 2) % 4)) : 4'b0000;
         chk("t2_grant", 32'(grant_o), 32'(exp_g));
      end
      for (int p = 0; p < 2; p++)
         for (int i = 0; i < 4; i++) exp_q.push_back({8'(i), 8'(p), 16'h0000});
      chk_stream("t2_stream");

      // Granted input 1 drops tvalid for 2 cycles while input 3 requests
      load(1, 1, 3);
      load(3, 1, 1);
      for (int i = 0; i < 8; i++) begin
         tick();
         chk("t3_grant", 32'(grant_o), 32'(exp3[i]));
         if (i == 0) chk("t3_tid", 32'(out_if.tid), 32'h1);
         if (i == 2) chk("t3_tvalid_drop", 32'(out_if.tvalid), 32'h0);
         if (i == 1) hold[1] = 1'b1;
         if (i == 3) hold[1] = 1'b0;
      end
      for (int i = 0; i < 3; i++) exp_q.push_back(32'h0100_0000 + 32'(i));
      exp_q.push_back(32'h0300_0000);
      chk_stream("t3_stream");

      // Downstream backpressure for 5 cycles in the middle of a 4-word packet
      load(0, 1, 4);
      for (int i = 0; i < 10; i++) begin
         tick();
         chk("t4_grant", 32'(grant_o), (i <= 8) ? 32'h1 : 32'h0);
         if (i >= 2 && i <= 6) begin
            chk("t4_hold_data", out_if.tdata, 32'h0000_0001);
            chk("t4_hold_valid", 32'(out_if.tvalid), 32'h1);
            chk("t4_hold_ready", 32'(src_ready), 32'h0);
            chk("t4_hold_busy", 32'(busy_o), 32'h1);
         end
         if (i == 1) out_ready = 1'b0;
         if (i == 6) out_ready = 1'b1;
      end
      chk("t4_end_busy", 32'(busy_o), 32'h0);
      for (int i = 0; i < 4; i++) exp_q.push_back(32'h0000_0000 + 32'(i));
      chk_stream("t4_stream");

      // Reset during the second word of a 4-word packet from input 3
      load(3, 1, 4);
      tick();
      chk("t5_grant3", 32'(grant_o), 32'h8);
      tick();
      chk("t5_word2", out_if.tdata, 32'h0300_0001);
      rst_i = 1'b1;
      #1;
      chk("t5_rst_grant", 32'(grant_o), 32'h0);
      chk("t5_rst_busy", 32'(busy_o), 32'h0);
      chk("t5_rst_tvalid", 32'(out_if.tvalid), 32'h0);
      chk("t5_rst_tready", 32'(src_ready), 32'h0);
      tick();
      rst_i = 1'b0;
      #1;
      chk("t5_idle_grant", 32'(grant_o), 32'h0);
      load(1, 1, 1);
      tick();
      chk("t5_lowest", 32'(grant_o), 32'h2);
      tick();
      chk("t5_bubble", 32'(grant_o), 32'h0);
      tick();
      chk("t5_resume_grant", 32'(grant_o), 32'h8);
      chk("t5_resume_word", out_if.tdata, 32'h0300_0001);
      tick();
      tick();
      tick();
      chk("t5_end_grant", 32'(grant_o), 32'h0);
      exp_q.push_back(32'h0300_0000);
      exp_q.push_back(32'h0100_0000);
      for (int i = 1; i < 4; i++) exp_q.push_back(32'h0300_0000 + 32'(i));
      chk_stream("t5_stream");

`ifdef AXI4_STREAM_PKT_ARBITER_PKT_CNT_EN
      // Completed-packet counters: 5 packets on input 2, 3 on input 0
      rst_i = 1'b1;
      tick();
      rst_i = 1'b0;
      chk("cnt_rst", pkt_cnt_o[95:64], 32'h0);
      load(2, 5, 1);
      load(0, 3, 2);
      for (int i = 0; i < 40; i++) tick();
      chk("cnt0", pkt_cnt_o[31:0], 32'd3);
      chk("cnt1", pkt_cnt_o[63:32], 32'd0);
      chk("cnt2", pkt_cnt_o[95:64], 32'd5);
      chk("cnt3", pkt_cnt_o[127:96], 32'd0);
      got_q.delete();
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
